// File: rtl/vproc_mem_model.sv
// vproc_mem_model: multi-port, latency-configurable word memory with grant stalls and program-end detect
module vproc_mem_model #(
  parameter int unsigned PORTS        = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_SZ       = 262144,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STALL_PERIOD = 0,
  parameter logic [31:0] END_ADDR     = 32'h0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [PORTS-1:0]                   req_i,
  output logic [PORTS-1:0]                   gnt_o,
  input  logic [PORTS-1:0][31:0]             addr_i,
  input  logic [PORTS-1:0]                   we_i,
  input  logic [PORTS-1:0][DATA_W/8-1:0]     be_i,
  input  logic [PORTS-1:0][DATA_W-1:0]       wdata_i,
  output logic [PORTS-1:0]                   rvalid_o,
  output logic [PORTS-1:0][DATA_W-1:0]       rdata_o,
  output logic [PORTS-1:0]                   err_o,
  output logic                               prog_end_o
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned BW    = $clog2(NB);
  localparam int unsigned AW    = $clog2(MEM_SZ);
  localparam int unsigned WORDS = MEM_SZ / NB;
  localparam int unsigned SW    = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD > 1 ? STALL_PERIOD - 1 : 0);

  logic [DATA_W-1:0]                           mem_q [WORDS];
  logic [SW-1:0]                               r_stall_cnt;
  logic                                        r_prog_end;
  logic [PORTS-1:0][LATENCY-1:0]               r_vld;
  logic [PORTS-1:0][LATENCY-1:0]               r_err;
  logic [PORTS-1:0][LATENCY-1:0][DATA_W-1:0]   r_dat;
  logic [PORTS-1:0]                            w_acc;
  logic [PORTS-1:0]                            w_oor;
  logic [PORTS-1:0][AW-BW-1:0]                 w_idx;
  logic [PORTS-1:0][DATA_W-1:0]                w_rd;

  // Grant comes only from the stall counter, so no request-to-output path exists
  always_comb begin
    gnt_o = (STALL_PERIOD > 1 && r_stall_cnt == STALL_LAST) ? '0 : '1;
    for (int p = 0; p < int'(PORTS); p++) begin
      w_oor[p] = |addr_i[p][31:AW];
      w_idx[p] = addr_i[p][AW-1:BW];
      w_acc[p] = rst_ni & req_i[p] & gnt_o[p];
      w_rd[p]  = (w_oor[p] || !w_acc[p]) ? '0 : mem_q[w_idx[p]];
    end
  end

  // Free-running stall counter wrapping at STALL_PERIOD-1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stall_cnt <= '0;
    else r_stall_cnt <= (STALL_PERIOD < 2 || r_stall_cnt == STALL_LAST) ? '0 : r_stall_cnt + 1'b1;
  end

  // Byte writes; higher ports applied first so the lowest index wins overlapping bytes
  always_ff @(posedge clk_i) begin
    for (int p = int'(PORTS) - 1; p >= 0; p--)
      for (int b = 0; b < int'(NB); b++)
        if (w_acc[p] && we_i[p] && !w_oor[p] && be_i[p][b])
          mem_q[w_idx[p]][8*b +: 8] <= wdata_i[p][8*b +: 8];
  end

  // Response shift pipelines capture data at acceptance; program-end pulse registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld      <= '0;
      r_err      <= '0;
      r_dat      <= '0;
      r_prog_end <= 1'b0;
    end else begin
      for (int p = 0; p < int'(PORTS); p++) begin
        r_vld[p] <= LATENCY'({r_vld[p], w_acc[p]});
        r_err[p] <= LATENCY'({r_err[p], w_acc[p] & w_oor[p]});
        r_dat[p] <= (LATENCY * DATA_W)'({r_dat[p], w_rd[p]});
      end
      r_prog_end <= w_acc[0] && addr_i[0] == END_ADDR;
    end
  end

  // Outputs taken from the last pipeline stage
  always_comb begin
    for (int p = 0; p < int'(PORTS); p++) begin
      rvalid_o[p] = r_vld[p][LATENCY-1];
      err_o[p]    = r_err[p][LATENCY-1];
      rdata_o[p]  = r_dat[p][LATENCY-1];
    end
    prog_end_o = r_prog_end;
  end
endmodule

// File: tb/tb_vproc_mem_model.sv
// tb_vproc_mem_model: randomized scoreboard bench for the multi-port memory model
module tb_vproc_mem_model;
  localparam int LAT = 4;
  localparam logic [31:0] END = 32'h80;

  typedef struct {
    longint      due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [1:0]       req_i = '0, we_i = '0, gnt_o, rvalid_o, err_o;
  logic [1:0][31:0] addr_i = '0, wdata_i = '0, rdata_o;
  logic [1:0][3:0]  be_i = '0;
  logic             prog_end_o;

  logic [31:0] mdl [128];
  exp_t        sb [2][$];
  longint      edge_n = 0;
  int          st = 0;
  logic        exp_pe = 1'b0;
  int          n_cmp = 0, n_fail = 0;

  vproc_mem_model #(
    .PORTS(2), .DATA_W(32), .MEM_SZ(262144), .LATENCY(LAT), .STALL_PERIOD(3), .END_ADDR(END)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .prog_end_o(prog_end_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni)
      for (int p = 0; p < 2; p++) begin
        if (rvalid_o[p]) begin
          if (sb[p].size() == 0) chk("unexpected_rvalid", 64'(rvalid_o[p]), 0);
          else begin
            e = sb[p].pop_front();
            chk("rdata", rdata_o[p], e.data);
            chk("err", err_o[p], e.err);
            chk("resp_time", edge_n, e.due);
          end
        end else if (sb[p].size() != 0 && sb[p][0].due <= edge_n) begin
          chk("missing_rvalid", 64'(rvalid_o[p]), 1);
          void'(sb[p].pop_front());
        end
      end
  end

  // One request cycle at a negedge; held until granted when hold is set
  task automatic step(input logic [1:0] rq, input logic [1:0] w, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [3:0] b0, input logic [3:0] b1, input logic [31:0] d0, input logic [31:0] d1,
                      input bit hold);
    logic        g;
    logic [31:0] a [2];
    logic [3:0]  be [2];
    logic [31:0] d [2];
    logic        oor [2];
    int          idx [2];
    exp_t        e;
    a[0] = a0; a[1] = a1; be[0] = b0; be[1] = b1; d[0] = d0; d[1] = d1;
    do begin
      req_i = rq; we_i = w; addr_i[0] = a0; addr_i[1] = a1;
      be_i[0] = b0; be_i[1] = b1; wdata_i[0] = d0; wdata_i[1] = d1;
      g = (st != 2);
      chk("gnt", gnt_o, g ? 2'b11 : 2'b00);
      chk("prog_end", prog_end_o, exp_pe);
      exp_pe = g && rq[0] && a0 == END;
      if (g) begin
        for (int p = 0; p < 2; p++) begin
          oor[p] = a[p][31:18] != 0;
          idx[p] = int'(a[p][8:2]);
          if (rq[p]) begin
            e.due  = edge_n + LAT;
            e.err  = oor[p];
            e.data = oor[p] ? 32'h0 : mdl[idx[p]];
            sb[p].push_back(e);
          end
        end
        for (int p = 1; p >= 0; p--)
          if (rq[p] && w[p] && !oor[p])
            for (int bi = 0; bi < 4; bi++)
              if (be[p][bi]) mdl[idx[p]][8*bi +: 8] = d[p][8*bi +: 8];
      end
      @(posedge clk);
      st = (st + 1) % 3;
      @(negedge clk);
    end while (hold && !g && rq != 0);
    req_i = '0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 19);
    if (r == 0) return 32'h40000 | 32'($urandom_range(0, 511));
    if (r == 1) return END;
    if (r < 6) return 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 511));
  endfunction

  task automatic rnd_steps(input int n);
    for (int i = 0; i < n; i++)
      step(2'($urandom), 2'($urandom), rnd_addr(), rnd_addr(), 4'($urandom), 4'($urandom),
           $urandom, $urandom, bit'($urandom_range(0, 3) != 0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rvalid", rvalid_o, 0);
    chk("reset_prog_end", prog_end_o, 0);
    chk("reset_gnt", gnt_o, 2'b11);
    rst_ni = 1'b1;
    st = 0;
    for (int i = 0; i < 64; i++)
      step(2'b11, 2'b11, 32'(8 * i), 32'(8 * i + 4), 4'hF, 4'hF, $urandom, $urandom, 1);
    step(2'b01, 2'b01, 32'h100, 0, 4'hF, 0, 32'hDEADBEEF, 0, 1);
    step(2'b01, 2'b00, 32'h100, 0, 0, 0, 0, 0, 1);
    step(2'b11, 2'b11, 32'h40, 32'h40, 4'h3, 4'hF, 32'h1111, 32'h22222222, 1);
    step(2'b01, 2'b00, 32'h40, 0, 0, 0, 0, 0, 1);
    step(2'b11, 2'b01, 32'h40, 32'h42, 4'hF, 0, 32'h33333333, 0, 1);
    step(2'b11, 2'b00, 32'h40, 32'h40, 0, 0, 0, 0, 1);
    step(2'b01, 2'b00, 32'h40000, 0, 0, 0, 0, 0, 1);
    step(2'b01, 2'b01, 32'h40040, 0, 4'hF, 0, 32'hBAD0BAD0, 0, 1);
    step(2'b01, 2'b00, 32'h40, 0, 0, 0, 0, 0, 1);
    step(2'b01, 2'b00, END, 0, 0, 0, 0, 0, 1);
    step(2'b10, 2'b00, 0, END, 0, 0, 0, 0, 1);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(2'b01, 2'b00, 32'(4 * i), 0, 0, 0, 0, 0, 1);
    rnd_steps(800);
    for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 32'(4 * i), 0, 0, 0, 0, 0, 1);
    #2 rst_ni = 1'b0;
    #1 chk("rst_rvalid", rvalid_o, 0);
    chk("rst_prog_end", prog_end_o, 0);
    sb[0].delete();
    sb[1].delete();
    exp_pe = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt_o, 2'b11);
    rst_ni = 1'b1;
    st = 0;
    for (int i = 0; i < 128; i += 2)
      step(2'b11, 2'b00, 32'(4 * i), 32'(4 * i + 4), 0, 0, 0, 0, 1);
    rnd_steps(800);
    repeat (LAT + 3) step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_p0", 64'(sb[0].size()), 0);
    chk("drain_p1", 64'(sb[1].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
